nco_phase_gen: RTL and testbench
================================

NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 24: phase accumulator width in bits.
REQ-002 SHALL have parameter OUT_W, default 8: phase index width, matching the sine table input.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_enable, input, 1 bit: advance the accumulator this cycle.
REQ-006 SHALL have port i_sync, input, 1 bit: clear the accumulator (phase restart).
REQ-007 SHALL have port i_ftw_valid, input, 1 bit: frequency tuning word offered.
REQ-008 SHALL have port i_ftw, input, ACC_W bits: frequency tuning word.
REQ-009 SHALL have port o_ftw_ready, output, 1 bit: block can accept a tuning word.
REQ-010 SHALL have port i_phase_off, input, OUT_W bits: phase offset added to the output index.
REQ-011 SHALL have port o_phase, output, OUT_W bits: registered phase index to the sine table data input.
REQ-012 SHALL have port o_valid, output, 1 bit: o_phase holds a new sample.
REQ-013 SHALL have port o_wrap, output, 1 bit: accumulator carried out on this sample.

Function
REQ-014 SHALL implement states IDLE (no tuning word loaded), RUN (active tuning word) and PEND (new word held, awaiting wrap).
REQ-015 SHALL accept a tuning word on any edge where i_ftw_valid and o_ftw_ready are both 1.
REQ-016 SHALL drive o_ftw_ready=1 in IDLE and RUN, and 0 in PEND.
REQ-017 SHALL, in IDLE on accept, load the word into the active register at once and go to RUN.
REQ-018 SHALL, in RUN on accept, store the word in the pending register and go to PEND.
REQ-019 SHALL, in PEND, copy pending to active on the edge where the enabled addition carries out, then go to RUN (phase-continuous retune).
REQ-020 SHALL, when i_enable=1, register o_phase = acc[ACC_W-1 -: OUT_W] + i_phase_off mod 2^OUT_W, using the pre-increment acc.
REQ-021 SHALL, in the same enabled cycle, update acc = (acc + active) mod 2^ACC_W, with o_wrap = carry out of that addition and o_valid=1.
REQ-022 SHALL, when i_enable=0, hold acc and o_phase and drive o_valid=0 and o_wrap=0.
REQ-023 SHALL make an active word of 0 hold acc constant, never wrap, and still produce valid samples.
REQ-024 SHALL, on i_sync=1, set acc=0, o_valid=0 and o_wrap=0, and apply any pending word immediately (PEND goes to RUN); i_sync overrides i_enable.
REQ-025 SHALL, when i_sync and an accept occur on the same edge, make the accepted word active immediately, with acc=0.
REQ-026 SHALL have a latency of 1 cycle from an enabled edge to o_phase/o_valid.

Reset
REQ-027 SHALL, on an edge with i_reset=1, set acc=0, active=0, pending=0, state IDLE, o_phase=0, o_valid=0, o_wrap=0, o_ftw_ready=1.
REQ-028 SHALL give i_reset priority over i_sync, i_enable and handshakes, and discard a pending word on reset mid-operation.

Structure
REQ-029 SHALL place ACC_W/OUT_W defaults and the state enumeration in shared package nco_pkg.
REQ-030 SHALL isolate the tuning-word handshake and pending/active registers in one sub-module, nco_ftw_buf; the accumulator stays in the top level.

Verification (ACC_W=24, OUT_W=8)
REQ-031 SHALL check: FTW 0x010000 accepted, i_enable=1 for 258 cycles, offset 0 -> o_phase 0x00,0x01,...,0xFF,0x00,0x01, with o_wrap=1 on the 0xFF sample only.
REQ-032 SHALL check: i_phase_off=0x80 with FTW 0x010000 -> o_phase starts at 0x80, 0x81, ..., wraps to 0x00 after 0xFF, and o_wrap still follows acc carry.
REQ-033 SHALL check: in RUN with FTW 0x010000 at acc 0x100000, offer 0x020000 -> o_ftw_ready drops; the step stays 1 until the wrap sample, then becomes 2; ready returns to 1.
REQ-034 SHALL check: i_sync mid-run with a word pending -> o_valid=0 that cycle, next enabled sample o_phase=0x00, using the new step.
REQ-035 SHALL check: i_enable toggling 1,0,1 -> o_phase held and o_valid=0 on the gap, with no skipped index.
REQ-036 SHALL check: i_reset asserted in PEND -> all outputs 0, o_ftw_ready=1, and the next accept loads directly (IDLE behaviour).

Source files
------------

// File: rtl/nco_pkg.sv
// Shared defaults and state enumeration for the NCO phase generator.
package nco_pkg;

   localparam int unsigned NCO_ACC_W = 24;
   localparam int unsigned NCO_OUT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } nco_state_e;

endpackage : nco_pkg

// File: rtl/nco_ftw_buf.sv
// Tuning-word handshake with active/pending registers; a pending word is
// promoted on accumulator carry or sync so retunes stay phase-continuous.
module nco_ftw_buf
   import nco_pkg::*;
#(
   parameter int unsigned ACC_W = NCO_ACC_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_sync,
   input  logic             i_carry,
   input  logic             i_ftw_valid,
   input  logic [ACC_W-1:0] i_ftw,
   output logic             o_ftw_ready,
   output logic [ACC_W-1:0] o_active
);

   nco_state_e       state_q, state_d;
   logic [ACC_W-1:0] active_q, active_d;
   logic [ACC_W-1:0] pending_q, pending_d;
   logic             accept;

   assign accept   = i_ftw_valid & o_ftw_ready;
   assign o_active = active_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         active_q  <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      pending_d = pending_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               active_d = i_ftw;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // A word accepted together with sync becomes active at once.
            if (accept && i_sync) begin
               active_d = i_ftw;
            end else if (accept) begin
               pending_d = i_ftw;
               state_d   = ST_PEND;
            end
         end
         ST_PEND: begin
            if (i_sync || i_carry) begin
               active_d = pending_q;
               state_d  = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ftw_ready = (state_q != ST_PEND);
   end

endmodule : nco_ftw_buf

// File: rtl/nco_phase_gen.sv
// Phase accumulator NCO: registered phase index with offset, wrap flag on
// accumulator carry, and phase-continuous tuning-word updates.
module nco_phase_gen
   import nco_pkg::*;
#(
   parameter int unsigned ACC_W = NCO_ACC_W,
   parameter int unsigned OUT_W = NCO_OUT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_sync,
   input  logic             i_ftw_valid,
   input  logic [ACC_W-1:0] i_ftw,
   output logic             o_ftw_ready,
   input  logic [OUT_W-1:0] i_phase_off,
   output logic [OUT_W-1:0] o_phase,
   output logic             o_valid,
   output logic             o_wrap
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] phase_q, phase_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [ACC_W-1:0] active;
   logic [ACC_W:0]   sum;
   logic             carry_en;

   assign sum      = {1'b0, acc_q} + {1'b0, active};
   assign carry_en = i_enable & ~i_sync & sum[ACC_W];

   nco_ftw_buf #(
      .ACC_W (ACC_W)
   ) u_ftw_buf (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_sync      (i_sync),
      .i_carry     (carry_en),
      .i_ftw_valid (i_ftw_valid),
      .i_ftw       (i_ftw),
      .o_ftw_ready (o_ftw_ready),
      .o_active    (active)
   );

   always_comb begin
      acc_d   = acc_q;
      phase_d = phase_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (i_sync) begin
         acc_d = '0;
      end else if (i_enable) begin
         phase_d = acc_q[ACC_W-1 -: OUT_W] + i_phase_off;
         acc_d   = sum[ACC_W-1:0];
         valid_d = 1'b1;
         wrap_d  = sum[ACC_W];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_q   <= '0;
         phase_q <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_phase = phase_q;
   assign o_valid = valid_q;
   assign o_wrap  = wrap_q;

endmodule : nco_phase_gen

// File: tb/tb_nco_phase_gen.sv
// Scoreboard bench for nco_phase_gen: driver pushes model expectations,
// monitor pops and compares one edge later.
module tb_nco_phase_gen;

   localparam int unsigned AW = 24;
   localparam int unsigned OW = 8;

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_enable = 1'b0;
   logic          i_sync = 1'b0;
   logic          i_ftw_valid = 1'b0;
   logic [AW-1:0] i_ftw = '0;
   logic          o_ftw_ready;
   logic [OW-1:0] i_phase_off = '0;
   logic [OW-1:0] o_phase;
   logic          o_valid;
   logic          o_wrap;

   always #5 clk = ~clk;

   nco_phase_gen #(
      .ACC_W (AW),
      .OUT_W (OW)
   ) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_enable    (i_enable),
      .i_sync      (i_sync),
      .i_ftw_valid (i_ftw_valid),
      .i_ftw       (i_ftw),
      .o_ftw_ready (o_ftw_ready),
      .i_phase_off (i_phase_off),
      .o_phase     (o_phase),
      .o_valid     (o_valid),
      .o_wrap      (o_wrap)
   );

   typedef struct {
      bit       valid;
      bit       wrap;
      bit       chk_phase;
      bit [7:0] phase;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: plain arithmetic on the accumulator and tuning words.
   longint unsigned m_acc = 0, m_active = 0, m_pending = 0;
   bit              m_loaded = 0, m_has_pend = 0, m_init = 0, m_phase_known = 0;
   bit [7:0]        m_phase = 0;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic cyc(input bit rst, input bit sy, input bit en, input bit fv,
                      input bit [AW-1:0] w, input bit [OW-1:0] off);
      exp_t e;
      bit   ready, accept, carry;
      longint unsigned sum;
      @(negedge clk);
      i_reset = rst; i_sync = sy; i_enable = en;
      i_ftw_valid = fv; i_ftw = w; i_phase_off = off;
      ready = !m_has_pend;
      if (m_init) chk("ftw_ready", o_ftw_ready, ready);
      accept = fv && ready;
      e = '{valid: 0, wrap: 0, chk_phase: 0, phase: 0};
      if (rst) begin
         m_acc = 0; m_active = 0; m_pending = 0;
         m_loaded = 0; m_has_pend = 0; m_init = 1;
         m_phase = 0; m_phase_known = 1;
         e.chk_phase = 1;
      end else if (sy) begin
         m_acc = 0;
         m_phase_known = 0;
         if (m_has_pend) begin
            m_active = m_pending; m_has_pend = 0;
         end
         if (accept) begin
            m_active = w; m_loaded = 1;
         end
      end else begin
         carry = 0;
         if (en) begin
            m_phase = 8'((m_acc >> (AW - OW)) + off);
            m_phase_known = 1;
            sum = m_acc + m_active;
            carry = (sum >= (64'd1 << AW));
            m_acc = sum % (64'd1 << AW);
            e.valid = 1; e.wrap = carry;
         end
         e.chk_phase = m_phase_known;
         e.phase = m_phase;
         if (m_has_pend && carry) begin
            m_active = m_pending; m_has_pend = 0;
         end
         if (accept) begin
            if (!m_loaded) begin
               m_active = w; m_loaded = 1;
            end else begin
               m_pending = w; m_has_pend = 1;
            end
         end
      end
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("o_valid", o_valid, e.valid);
            chk("o_wrap", o_wrap, e.wrap);
            if (e.chk_phase) chk("o_phase", o_phase, e.phase);
         end
      end
   end

   initial begin : driver
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      // Unit step: full sweep with wrap on 0xFF sample only.
      cyc(0, 0, 0, 1, 24'h010000, 0);
      for (int i = 0; i < 258; i++) cyc(0, 0, 1, 0, 0, 8'h00);
      // Phase offset 0x80.
      cyc(0, 1, 0, 0, 0, 8'h80);
      for (int i = 0; i < 258; i++) cyc(0, 0, 1, 0, 0, 8'h80);
      // Retune held pending until wrap.
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 24'h020000, 0);
      for (int i = 0; i < 250; i++) cyc(0, 0, 1, 0, 0, 0);
      // Sync with pending word applies it at once.
      cyc(0, 0, 1, 1, 24'h010000, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
      // Sync together with accept.
      cyc(0, 1, 1, 1, 24'h040000, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
      // Enable gaps.
      for (int i = 0; i < 12; i++) cyc(0, 0, (i % 3) != 1, 0, 0, 8'h11);
      // Reset while pending, then direct load.
      cyc(0, 0, 1, 1, 24'h080000, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 24'h0F0000, 0);
      cyc(0, 0, 0, 1, 24'h030000, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0);
      // Zero word: constant acc, no wrap, valid samples.
      cyc(0, 1, 0, 1, 24'h000000, 8'h05);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 8'h05);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit [AW-1:0] w;
         case ($urandom_range(0, 3))
            0:       w = '0;
            1:       w = AW'($urandom);
            default: w = AW'($urandom_range(24'h010000, 24'h200000));
         endcase
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
             w, OW'($urandom));
      end
      @(posedge clk);
      #2;
      chk("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_nco_phase_gen
